// File: rtl/pred_checker.sv
// pred_checker: delays branch outcomes LATENCY cycles, compares them with the
// predictor's outputs and keeps saturating hit/miss statistics behind a
// four-state run/drain/report FSM.
//
// Parameters:
//   Direction_SIZE - address / PC width
//   LATENCY        - cycles from outcome at the inputs to matching prediction (1..8)
//   CNT_WIDTH      - width of every statistics counter
// Ports:
//   clk, reset (async, active-low)
//   enable, clear                           - run request, synchronous counter clear
//   was_branch, branch_result, next_PC,
//   direction                               - actual outcome of the current instruction
//   prediction, predicted_PC                - predictor outputs, LATENCY cycles later
//   mispredict, miss_direction              - direction-miss pulse and its address
//   total_checked, dir_miss, target_miss    - saturating statistics
//   rpt_valid / rpt_ready                   - report handshake, busy in RUN/DRAIN
// Configuration:
//   PRED_CHECKER_TARGET_EN - when defined, compare targets and count target_miss;
//                            otherwise target_miss is 0 and next_PC is not stored.
module pred_checker #(
    parameter int Direction_SIZE = 32,
    parameter int LATENCY        = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      was_branch,
    input  logic                      branch_result,
    input  logic [Direction_SIZE-1:0] next_PC,
    input  logic [Direction_SIZE-1:0] direction,
    input  logic                      prediction,
    input  logic [Direction_SIZE-1:0] predicted_PC,
    output logic                      mispredict,
    output logic [Direction_SIZE-1:0] miss_direction,
    output logic [CNT_WIDTH-1:0]      total_checked,
    output logic [CNT_WIDTH-1:0]      dir_miss,
    output logic [CNT_WIDTH-1:0]      target_miss,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    state_t                                  state_q, state_d;
    logic [3:0]                              drain_q, drain_d;
    logic [LATENCY-1:0]                      wb_q, br_q;
    logic [LATENCY-1:0][Direction_SIZE-1:0]  dir_q;
    logic [CNT_WIDTH-1:0]                    tot_q, tot_d, dm_q, dm_d;
    logic                                    misp_q, misp_d;
    logic [Direction_SIZE-1:0]               md_q, md_d;
    logic                                    clr, cmp, dmiss;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN: begin
                state_d = enable ? RUN : DRAIN;
                drain_d = '0;
            end
            DRAIN: begin
                state_d = (drain_q == 4'(LATENCY - 1)) ? REPORT : DRAIN;
                drain_d = drain_q + 4'd1;
            end
            REPORT:  state_d = rpt_ready ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign rpt_valid = (state_q == REPORT);

    // clear wins over a same-cycle compare; REPORT freezes the counters
    assign clr   = clear && (state_q != REPORT);
    assign cmp   = wb_q[LATENCY-1] && busy && !clr;
    assign dmiss = prediction != br_q[LATENCY-1];

    always_comb begin
        tot_d  = clr ? '0 : cmp ? sat_inc(tot_q) : tot_q;
        dm_d   = clr ? '0 : (cmp && dmiss) ? sat_inc(dm_q) : dm_q;
        misp_d = cmp && dmiss;
        md_d   = (cmp && dmiss) ? dir_q[LATENCY-1] : md_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= '0;
            wb_q    <= '0;
            br_q    <= '0;
            dir_q   <= '0;
            tot_q   <= '0;
            dm_q    <= '0;
            misp_q  <= 1'b0;
            md_q    <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wb_q[0]  <= was_branch;
            br_q[0]  <= branch_result;
            dir_q[0] <= direction;
            for (int i = 1; i < LATENCY; i++) begin
                wb_q[i]  <= wb_q[i-1];
                br_q[i]  <= br_q[i-1];
                dir_q[i] <= dir_q[i-1];
            end
            tot_q  <= tot_d;
            dm_q   <= dm_d;
            misp_q <= misp_d;
            md_q   <= md_d;
        end
    end

    assign total_checked  = tot_q;
    assign dir_miss       = dm_q;
    assign mispredict     = misp_q;
    assign miss_direction = md_q;

`ifdef PRED_CHECKER_TARGET_EN
    logic [LATENCY-1:0][Direction_SIZE-1:0] npc_q;
    logic [CNT_WIDTH-1:0]                   tm_q, tm_d;

    // only taken branches have a meaningful target
    assign tm_d = clr ? '0
                : (cmp && br_q[LATENCY-1] && (predicted_PC != npc_q[LATENCY-1])) ? sat_inc(tm_q)
                : tm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            npc_q <= '0;
            tm_q  <= '0;
        end else begin
            npc_q[0] <= next_PC;
            for (int i = 1; i < LATENCY; i++) npc_q[i] <= npc_q[i-1];
            tm_q <= tm_d;
        end
    end

    assign target_miss = tm_q;
`else
    logic unused_pc;
    assign unused_pc   = ^{next_PC, predicted_PC};
    assign target_miss = '0;
`endif
endmodule

// File: tb/tb_pred_checker.sv
// tb_pred_checker: directed, table-driven self-checking bench for pred_checker.
module tb_pred_checker;
`ifdef PRED_CHECKER_TARGET_EN
    localparam logic [31:0] TE = 32'd1;
`else
    localparam logic [31:0] TE = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0, clear = 1'b0, was_branch = 1'b0, branch_result = 1'b0;
    logic        prediction = 1'b0, rpt_ready = 1'b0;
    logic [31:0] next_PC = '0, direction = '0, predicted_PC = '0;

    logic        mispredict, rpt_valid, busy;
    logic [31:0] miss_direction, total_checked, dir_miss, target_miss;
    logic        s_mispredict, s_rpt_valid, s_busy;
    logic [31:0] s_miss_direction;
    logic [3:0]  s_total, s_dir_miss, s_target_miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pred_checker #(.Direction_SIZE(32), .LATENCY(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .was_branch(was_branch), .branch_result(branch_result), .next_PC(next_PC),
        .direction(direction), .prediction(prediction), .predicted_PC(predicted_PC),
        .mispredict(mispredict), .miss_direction(miss_direction),
        .total_checked(total_checked), .dir_miss(dir_miss), .target_miss(target_miss),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .busy(busy)
    );

    pred_checker #(.Direction_SIZE(32), .LATENCY(2), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .was_branch(was_branch), .branch_result(branch_result), .next_PC(next_PC),
        .direction(direction), .prediction(prediction), .predicted_PC(predicted_PC),
        .mispredict(s_mispredict), .miss_direction(s_miss_direction),
        .total_checked(s_total), .dir_miss(s_dir_miss), .target_miss(s_target_miss),
        .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready), .busy(s_busy)
    );

    typedef struct {
        logic [31:0] en, wb, br, dir, npc, pred, ppc;
        logic [31:0] misp, tot, dm, tm, busy, rv, md;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en wb br dir npc pred ppc | misp tot dm tm busy rv md
        tv[0]  = '{1, 1, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tv[1]  = '{1, 1, 0, 'h101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tv[2]  = '{1, 1, 1, 'h102, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        tv[3]  = '{1, 1, 1, 'h103, 0, 1, 0, 1, 2, 1, 0, 1, 0, 'h101};
        tv[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 1, 0, 'h101};
        tv[5]  = '{1, 0, 0, 0, 0, 0, 0, 1, 4, 2, 0, 1, 0, 'h103};
        tv[6]  = '{1, 1, 1, 'h104, 'hBBBBBBBB, 0, 0, 0, 4, 2, 0, 1, 0, 'h103};
        tv[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 1, 0, 'h103};
        tv[8]  = '{1, 0, 0, 0, 0, 1, 'hFFFFFFFF, 0, 5, 2, 1, 1, 0, 'h103};
        tv[9]  = '{1, 1, 0, 'h105, 0, 0, 0, 0, 5, 2, 1, 1, 0, 'h103};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 2, 1, 1, 0, 'h103};
        tv[11] = '{1, 0, 0, 0, 0, 1, 0, 1, 6, 3, 1, 1, 0, 'h105};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 3, 1, 0, 1, 'h105};

        #2;
        chk("reset_tot", total_checked, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rv", rpt_valid, 0);
        chk("reset_misp", mispredict, 0);
        step();
        reset = 1'b1;
        step();

        enable = 1'b1;
        step();
        chk("enter_run_busy", busy, 1);

        for (int i = 0; i < 13; i++) begin
            enable        = tv[i].en[0];
            was_branch    = tv[i].wb[0];
            branch_result = tv[i].br[0];
            direction     = tv[i].dir;
            next_PC       = tv[i].npc;
            prediction    = tv[i].pred[0];
            predicted_PC  = tv[i].ppc;
            step();
            chk($sformatf("v%0d_misp", i), mispredict, tv[i].misp);
            chk($sformatf("v%0d_tot", i), total_checked, tv[i].tot);
            chk($sformatf("v%0d_dm", i), dir_miss, tv[i].dm);
            chk($sformatf("v%0d_tm", i), target_miss, tv[i].tm * TE);
            chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d_rv", i), rpt_valid, tv[i].rv);
            chk($sformatf("v%0d_md", i), miss_direction, tv[i].md);
        end

        // report held without ready: everything frozen, clear ignored
        prediction = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clear = (i == 2);
            step();
            chk("hold_rv", rpt_valid, 1);
            chk("hold_tot", total_checked, 6);
            chk("hold_dm", dir_miss, 3);
            chk("hold_tm", target_miss, TE);
        end
        clear = 1'b0;
        rpt_ready = 1'b1;
        step();
        chk("handshake_rv", rpt_valid, 0);
        chk("handshake_busy", busy, 0);
        rpt_ready = 1'b0;

        // IDLE: delayed branches are not compared
        was_branch = 1'b1;
        branch_result = 1'b1;
        prediction = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_tot", total_checked, 6);
            chk("idle_misp", mispredict, 0);
        end
        was_branch = 1'b0;
        step();
        step();

        // clear beats a mispredicting compare
        enable = 1'b1;
        step();
        was_branch = 1'b1;
        branch_result = 1'b1;
        direction = 32'h200;
        step();
        was_branch = 1'b0;
        step();
        prediction = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_tot", total_checked, 0);
        chk("clr_dm", dir_miss, 0);
        chk("clr_tm", target_miss, 0);
        chk("clr_misp", mispredict, 0);
        chk("clr_md", miss_direction, 32'h105);

        // 20 misses: 32-bit counter reaches 20, 4-bit one saturates
        was_branch = 1'b1;
        branch_result = 1'b1;
        prediction = 1'b0;
        next_PC = '0;
        predicted_PC = '0;
        for (int i = 0; i < 20; i++) step();
        was_branch = 1'b0;
        step();
        step();
        chk("sat_dm32", dir_miss, 20);
        chk("sat_tot32", total_checked, 20);
        chk("sat_dm4", s_dir_miss, 4'hF);
        chk("sat_tot4", s_total, 4'hF);

        // asynchronous reset in the middle of RUN
        was_branch = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_tot", total_checked, 0);
        chk("rst_dm", dir_miss, 0);
        chk("rst_tm", target_miss, 0);
        chk("rst_md", miss_direction, 0);
        chk("rst_misp", mispredict, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", rpt_valid, 0);
        enable = 1'b0;
        was_branch = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_rv", rpt_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
